// File: rtl/downsample_engine.sv
// Frame downsampler: walks the source image block by block over a simple request/strobe
// memory bus and writes one pixel per block, either decimated (top-left) or box-averaged.
module downsample_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int FACTOR   = 2,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 'h8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wack
);

  localparam int OW      = IMG_W / FACTOR;
  localparam int OH      = IMG_H / FACTOR;
  localparam int LOG2F   = $clog2(FACTOR);
  localparam int ACC_W   = DATA_W + 2 * LOG2F;
  localparam int DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CNT_W   = $clog2(DIM_MAX + 1);
  localparam int BW      = LOG2F;

  localparam logic [CNT_W-1:0] OX_LAST = CNT_W'(OW - 1);
  localparam logic [CNT_W-1:0] OY_LAST = CNT_W'(OH - 1);
  localparam logic [BW-1:0]    B_LAST  = BW'(FACTOR - 1);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic              mode_q;
  logic [CNT_W-1:0]  ox, oy, ox_nxt, oy_nxt;
  logic [BW-1:0]     bx, by, bx_nxt, by_nxt;
  logic [ACC_W-1:0]  acc, acc_sum;
  logic              blk_last, px_last, rd_fin;

  // Source address of pixel (bx,by) inside output block (ox,oy); wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [CNT_W-1:0] ox_v,
                                                  input logic [CNT_W-1:0] oy_v,
                                                  input logic [BW-1:0]    bx_v,
                                                  input logic [BW-1:0]    by_v);
    int x, y;
    x = int'(ox_v) * FACTOR + int'(bx_v);
    y = int'(oy_v) * FACTOR + int'(by_v);
    return ADDR_W'(SRC_BASE + y * IMG_W + x);
  endfunction

  function automatic logic [ADDR_W-1:0] dst_addr(input logic [CNT_W-1:0] ox_v,
                                                  input logic [CNT_W-1:0] oy_v);
    return ADDR_W'(DST_BASE + int'(oy_v) * OW + int'(ox_v));
  endfunction

  // Box mean with truncation: divide by FACTOR^2 via shift.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
    return DATA_W'(s >> (2 * LOG2F));
  endfunction

  assign blk_last = (bx == B_LAST) && (by == B_LAST);
  assign px_last  = (ox == OX_LAST) && (oy == OY_LAST);
  assign rd_fin   = !mode_q || blk_last;
  assign acc_sum  = acc + ACC_W'(mem_rdata);
  assign bx_nxt   = (bx == B_LAST) ? '0 : bx + 1'b1;
  assign by_nxt   = (bx == B_LAST) ? by + 1'b1 : by;
  assign ox_nxt   = (ox == OX_LAST) ? '0 : ox + 1'b1;
  assign oy_nxt   = (ox == OX_LAST) ? oy + 1'b1 : oy;

  assign busy   = (state == RD_REQ) || (state == WR_REQ);
  assign done   = (state == DONE);
  assign mem_rd = (state == RD_REQ);
  assign mem_wr = (state == WR_REQ);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_REQ;
      RD_REQ:  if (mem_rvalid && rd_fin) state_nxt = WR_REQ;
      WR_REQ:  if (mem_wack) state_nxt = px_last ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address, data, counters and accumulator only move on accepted strobes, so the bus stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 1'b0;
      ox        <= '0;
      oy        <= '0;
      bx        <= '0;
      by        <= '0;
      acc       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            ox       <= '0;
            oy       <= '0;
            bx       <= '0;
            by       <= '0;
            acc      <= '0;
            mem_addr <= src_addr('0, '0, '0, '0);
          end
        end
        RD_REQ: begin
          if (mem_rvalid) begin
            if (rd_fin) begin
              mem_wdata <= mode_q ? avg_trunc(acc_sum) : mem_rdata;
              mem_addr  <= dst_addr(ox, oy);
              acc       <= '0;
              bx        <= '0;
              by        <= '0;
            end else begin
              acc      <= acc_sum;
              bx       <= bx_nxt;
              by       <= by_nxt;
              mem_addr <= src_addr(ox, oy, bx_nxt, by_nxt);
            end
          end
        end
        WR_REQ: begin
          if (mem_wack && !px_last) begin
            ox       <= ox_nxt;
            oy       <= oy_nxt;
            mem_addr <= src_addr(ox_nxt, oy_nxt, '0, '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/downsample_engine.md
DOWNSAMPLE_ENGINE -- requirements
Module: downsample_engine

Interface
REQ-001 Parameter DATA_W, 8, pixel width in bits.
REQ-002 Parameter ADDR_W, 16, memory address width.
REQ-003 Parameter IMG_W, 16, source image width in pixels (>= FACTOR).
REQ-004 Parameter IMG_H, 16, source image height in pixels (>= FACTOR).
REQ-005 Parameter FACTOR, 2, downsample factor; power of two, 2..8.
REQ-006 Parameter SRC_BASE, 0, source image base address.
REQ-007 Parameter DST_BASE, 16'h8000, destination image base address.
REQ-008 Port clk, input, 1, single clock; all logic on rising edge.
REQ-009 Port reset, input, 1, synchronous, active-high reset.
REQ-010 Port start, input, 1, one-cycle request to begin a frame.
REQ-011 Port mode, input, 1, 0 = decimate (pick top-left pixel), 1 = box average; sampled on accepted start.
REQ-012 Port busy, output, 1, high from the cycle after an accepted start until done.
REQ-013 Port done, output, 1, one-cycle pulse at frame completion.
REQ-014 Port mem_addr, output, ADDR_W, read or write address.
REQ-015 Port mem_rd, output, 1, read request; held until mem_rvalid.
REQ-016 Port mem_rdata, input, DATA_W, read data; valid when mem_rvalid.
REQ-017 Port mem_rvalid, input, 1, read completion strobe.
REQ-018 Port mem_wr, output, 1, write request; held until mem_wack.
REQ-019 Port mem_wdata, output, DATA_W, write data.
REQ-020 Port mem_wack, input, 1, write completion strobe.

Function
REQ-021 Output size: OW = IMG_W/FACTOR, OH = IMG_H/FACTOR (integer division); leftover source columns and rows are never read.
REQ-022 States: IDLE, RD_REQ, WR_REQ, DONE.
REQ-023 IDLE -> RD_REQ on start; start while not in IDLE is ignored.
REQ-024 RD_REQ: mem_rd=1, mem_addr = SRC_BASE + y*IMG_W + x; mem_addr stable until mem_rvalid is sampled high.
REQ-025 Decimate: one read per output pixel at (x,y) = (ox*FACTOR, oy*FACTOR); on mem_rvalid, go to WR_REQ with mem_wdata = mem_rdata.
REQ-026 Average: FACTOR*FACTOR reads per output pixel, row-major within the block; accumulator width DATA_W + 2*log2(FACTOR) clears at block start; after the last read, mem_wdata = sum >> 2*log2(FACTOR) (truncating).
REQ-027 WR_REQ: mem_wr=1, mem_addr = DST_BASE + oy*OW + ox; mem_addr and mem_wdata stable until mem_wack.
REQ-028 After mem_wack: advance ox; wrap ox to 0 at OW and increment oy; after the last pixel (ox=OW-1, oy=OH-1), go to DONE, else go to RD_REQ.
REQ-029 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-030 mem_rd and mem_wr are never high together; each request is removed on the edge after its strobe.
REQ-031 mem_rvalid outside RD_REQ and mem_wack outside WR_REQ are ignored.
REQ-032 Address arithmetic wraps modulo 2^ADDR_W.
REQ-033 mode is latched at start; changes during a frame have no effect.

Reset
REQ-034 On reset, the next edge forces: state IDLE; busy, done, mem_rd, mem_wr = 0; mem_addr, mem_wdata, counters, and accumulator = 0.
REQ-035 Reset mid-frame aborts with no further requests; the next start restarts at (0,0).
REQ-036 Reset takes priority over start in the same cycle.

Verification
REQ-037 4x4, F=2, mode 0, src[i]=i, single-cycle strobes -> reads 0,2,8,10; writes 0,2,8,10 to 0x8000..0x8003; done pulses once.
REQ-038 4x4, F=2, mode 1, src[i]=i -> writes (0+1+4+5)>>2=2, 4, 10, 12 to 0x8000..0x8003.
REQ-039 mem_rvalid delayed 3 cycles and mem_wack delayed 2 cycles -> mem_rd/mem_wr and mem_addr/mem_wdata are held constant throughout; results are unchanged.
REQ-040 IMG_W=5, IMG_H=3, F=2, mode 0 -> OW=2, OH=1; reads addr 0 and 2 only; 2 writes.
REQ-041 Reset asserted while in WR_REQ -> next cycle mem_wr=0, busy=0; no further bus activity until a new start.
REQ-042 start pulsed while busy, and mode toggled mid-frame -> ignored; write count and values match the original frame.
